// File: rtl/fa_response_checker.sv
// fa_response_checker: in-fabric exhaustive checker for a 1-bit full adder.
// It sweeps all eight {a,b,cin} vectors PASSES times. Each vector is held for
// SETTLE cycles and then sampled in a one-cycle CHECK against a+b+cin. The
// block reports pass/fail, a saturating error count and the first failing
// vector.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request (honoured only in IDLE or DONE)
//   dut_a/dut_b/dut_cin   registered stimulus to the adder
//   dut_co/dut_s          adder outputs under test (sampled only in CHECK)
//   busy, done, pass      run status; pass is meaningful while done=1
//   err_count             mismatch count, saturating at 255
//   fail_vec, fail_seen   first failing {a,b,cin} and its valid flag
module fa_response_checker #(
    parameter int unsigned PASSES = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_cin,
    input  logic       dut_co,
    input  logic       dut_s,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] fail_vec,
    output logic       fail_seen
);

    localparam int unsigned WW = $clog2(SETTLE + 1);
    localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      vec_q, vec_d;
    logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]      err_count_q, err_count_d;
    logic [2:0]      fail_vec_q, fail_vec_d;
    logic            fail_seen_q, fail_seen_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [1:0]      expected_c;
    logic            mismatch_c;

    // Reference result for the vector currently driven: {carry, sum}.
    assign expected_c = {(vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]),
                         ^vec_q};
    assign mismatch_c = ({dut_co, dut_s} != expected_c);

    // Next-state and result update.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        pass_cnt_d  = pass_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_count_d = err_count_q;
        fail_vec_d  = fail_vec_q;
        fail_seen_d = fail_seen_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_SETTLE;
                    vec_d       = 3'd0;
                    pass_cnt_d  = '0;
                    wait_cnt_d  = WW'(SETTLE);
                    err_count_d = 8'd0;
                    fail_vec_d  = 3'd0;
                    fail_seen_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (wait_cnt_q == WW'(1)) begin
                    state_d = S_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end
            S_CHECK: begin
                // dut_co/dut_s only influence results in this state.
                if (mismatch_c) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    if (!fail_seen_q) begin
                        fail_vec_d  = vec_q;
                        fail_seen_d = 1'b1;
                    end
                end
                if (vec_q != 3'd7) begin
                    vec_d      = vec_q + 3'd1;
                    wait_cnt_d = WW'(SETTLE);
                    state_d    = S_SETTLE;
                end else if (pass_cnt_q != PW'(PASSES - 1)) begin
                    vec_d      = 3'd0;
                    pass_cnt_d = pass_cnt_q + PW'(1);
                    wait_cnt_d = WW'(SETTLE);
                    state_d    = S_SETTLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered copies of the state being entered.
        busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_count_d == 8'd0);
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= 3'd0;
            pass_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            err_count_q <= 8'd0;
            fail_vec_q  <= 3'd0;
            fail_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            pass_cnt_q  <= pass_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_count_q <= err_count_d;
            fail_vec_q  <= fail_vec_d;
            fail_seen_q <= fail_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign dut_a     = vec_q[2];
    assign dut_b     = vec_q[1];
    assign dut_cin   = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;
    assign fail_seen = fail_seen_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// Bench for fa_response_checker. Three checker instances drive a behavioural
// full adder with selectable faults: inst 0 uses the defaults, inst 1 uses
// PASSES=40 and inst 2 uses SETTLE=3.
module tb_fa_response_checker;

    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         mode = 0;   // 0 good, 1 s stuck-0, 2 co inverted, 3 glitch while settling

    logic       start_r   [3];
    logic       dut_a_w   [3];
    logic       dut_b_w   [3];
    logic       dut_cin_w [3];
    logic       co_w      [3];
    logic       s_w       [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic       pass_w    [3];
    logic [7:0] err_w     [3];
    logic [2:0] fv_w      [3];
    logic       fs_w      [3];
    logic [2:0] vec_w     [3];
    logic [2:0] last_q    [3];
    int         age_q     [3];

    int errors = 0;
    int checks = 0;
    logic [2:0] seq[$];

    always #5 clk = ~clk;

    function automatic logic [1:0] fa_model(input int m, input logic [2:0] v, input int idx);
        logic [1:0] r;
        r = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
        case (m)
            1: r[0] = 1'b0;
            2: r[1] = ~r[1];
            3: if (idx < 3) r = ~r;
            default: ;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        logic chg;
        int   idx;
        assign vec_w[g] = {dut_a_w[g], dut_b_w[g], dut_cin_w[g]};
        assign chg = (vec_w[g] != last_q[g]);
        assign idx = chg ? 0 : age_q[g];
        always_comb {co_w[g], s_w[g]} = fa_model(mode, vec_w[g], idx);
        always_ff @(posedge clk) begin
            last_q[g] <= vec_w[g];
            age_q[g]  <= chg ? 1 : age_q[g] + 1;
        end

        fa_response_checker #(
            .PASSES((g == 1) ? 40 : 3),
            .SETTLE((g == 2) ? 3 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_r[g]),
            .dut_a    (dut_a_w[g]),
            .dut_b    (dut_b_w[g]),
            .dut_cin  (dut_cin_w[g]),
            .dut_co   (co_w[g]),
            .dut_s    (s_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .pass     (pass_w[g]),
            .err_count(err_w[g]),
            .fail_vec (fv_w[g]),
            .fail_seen(fs_w[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start, then count edges until done. A start is reasserted at edge poke+1 when poke>0.
    task automatic run(input int inst, input int poke, output int lat);
        @(negedge clk);
        start_r[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_r[inst] = 1'b0;
        chk("start_busy", int'(busy_w[inst]), 1);
        chk("start_done_clr", int'(done_w[inst]), 0);
        chk("start_err_clr", int'(err_w[inst]), 0);
        seq.delete();
        seq.push_back(vec_w[inst]);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (vec_w[inst] != seq[$]) seq.push_back(vec_w[inst]);
            start_r[inst] = (poke > 0) && (lat == poke);
        end while (!done_w[inst] && lat < LIMIT);
        start_r[inst] = 1'b0;
    endtask

    typedef struct {
        int         inst;
        int         mode;
        int         exp_lat;
        int         exp_err;
        logic [2:0] exp_fv;
        logic       exp_fs;
        logic       exp_pass;
    } row_t;

    initial begin
        row_t tbl[5];
        int   lat;
        int   seq_ok;

        tbl[0] = '{0, 0, 48, 0, 3'b000, 1'b0, 1'b1};
        tbl[1] = '{0, 1, 48, 12, 3'b001, 1'b1, 1'b0};
        tbl[2] = '{0, 2, 48, 24, 3'b000, 1'b1, 1'b0};
        tbl[3] = '{1, 2, 640, 255, 3'b000, 1'b1, 1'b0};
        tbl[4] = '{2, 3, 96, 0, 3'b000, 1'b0, 1'b1};

        for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy_w[0]), 0);
        chk("reset_done", int'(done_w[0]), 0);
        chk("reset_pass", int'(pass_w[0]), 0);
        chk("reset_err", int'(err_w[0]), 0);
        chk("reset_vec", int'(vec_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int r = 0; r < 5; r++) begin
            mode = tbl[r].mode;
            run(tbl[r].inst, 0, lat);
            chk($sformatf("row%0d_latency", r), lat, tbl[r].exp_lat);
            chk($sformatf("row%0d_err", r), int'(err_w[tbl[r].inst]), tbl[r].exp_err);
            chk($sformatf("row%0d_fail_vec", r), int'(fv_w[tbl[r].inst]), int'(tbl[r].exp_fv));
            chk($sformatf("row%0d_fail_seen", r), int'(fs_w[tbl[r].inst]), int'(tbl[r].exp_fs));
            chk($sformatf("row%0d_pass", r), int'(pass_w[tbl[r].inst]), int'(tbl[r].exp_pass));
            chk($sformatf("row%0d_busy_end", r), int'(busy_w[tbl[r].inst]), 0);
            if (r == 0) begin
                seq_ok = (seq.size() == 24);
                for (int k = 0; k < seq.size() && k < 24; k++)
                    if (seq[k] != 3'(k % 8)) seq_ok = 0;
                chk("vector_sequence", seq_ok, 1);
            end
        end

        // start during a run is ignored
        mode = 0;
        run(0, 10, lat);
        chk("busy_start_latency", lat, 48);
        chk("busy_start_pass", int'(pass_w[0]), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", int'(done_w[0]), 1);
        chk("vec_held", int'(vec_w[0]), 7);

        // asynchronous reset mid-run
        mode = 2;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_reset_err_nonzero", int'(err_w[0] != 8'd0), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy_w[0]), 0);
        chk("async_rst_err", int'(err_w[0]), 0);
        chk("async_rst_fail_seen", int'(fs_w[0]), 0);
        chk("async_rst_vec", int'(vec_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", int'(busy_w[0]), 0);
        chk("post_rst_idle_done", int'(done_w[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
